ehr_reader: RTL and testbench

- Read-side counterpart of the entropy holding register (EHR) fill logic, clocked in the rng_clk domain.
- Snapshots the full EHR into a local shadow when the fill side reports it complete.
- Serves 32-bit CPU reads of the EHR words and, alternatively, hands the whole EHR to the PRNG as a seed over a valid/ack handshake.
- Tracks consumption and pulses a restart request back to the collector once the EHR has been fully drained.

---
 rtl/ehr_reader.sv | 159 +++++++++++++++
 tb/tb_ehr_reader.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ehr_reader.sv
// rtl/ehr_reader.sv - EHR shadow capture, CPU/PRNG read-out and drain tracking (optional macro: EHR_RD_ZEROIZE_EN)
module ehr_reader #(
    parameter int          EHR_WORDS     = 4,
    parameter logic [11:0] EHR_BASE_ADDR = 12'h114
) (
    input  logic                      rng_clk,
    input  logic                      rst_trng_logic,
    input  logic [32*EHR_WORDS-1:0]   ehr_data,
    input  logic                      ehr_full,
    input  logic                      curr_test_err,
    input  logic                      cpu_ehr_rd,
    input  logic [11:0]               cpu_rng_paddr,
    input  logic                      prng_seed_req,
    input  logic                      prng_seed_ack,
    output logic [31:0]               ehr_rdata,
    output logic                      ehr_valid,
    output logic                      prng_seed_valid,
    output logic [32*EHR_WORDS-1:0]   prng_seed_data,
    output logic                      ehr_rd_done
);

    localparam int SW = 32 * EHR_WORDS;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOADED = 2'd1,
        SEED   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [SW-1:0]        shadow_q, shadow_d;
    logic [EHR_WORDS-1:0] rd_mask_q, rd_mask_d;
    logic [31:0]          rdata_q, rdata_d;

    // The EHR window is an 8-word aligned region from the base address; slots
    // beyond EHR_WORDS decode as EHR offsets but read back as zero.
    logic [11:0]          offset;
    logic [2:0]           word_idx;
    logic                 in_window;
    logic                 idx_ok;
    logic                 rd_hit;
    logic [31:0]          sel_word;
    logic [EHR_WORDS-1:0] hit_onehot;
    logic                 has_data;

    assign offset    = cpu_rng_paddr - EHR_BASE_ADDR;
    assign word_idx  = offset[4:2];
    assign in_window = (offset[11:5] == 7'd0) && (offset[1:0] == 2'b00);
    assign idx_ok    = ({29'd0, word_idx} < 32'(EHR_WORDS));
    assign rd_hit    = cpu_ehr_rd && in_window;
    assign has_data  = (state_q == LOADED) || (state_q == SEED);

    // Word select and one-hot of the addressed EHR word
    always_comb begin
        sel_word   = 32'd0;
        hit_onehot = '0;
        for (int i = 0; i < EHR_WORDS; i++) begin
            if (word_idx == 3'(i)) begin
                sel_word      = shadow_q[i*32 +: 32];
                hit_onehot[i] = 1'b1;
            end
        end
    end

    // Next-state, shadow, consumption mask and read-data logic
    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        rd_mask_d = rd_mask_q;
        rdata_d   = rdata_q;

        if (rd_hit) begin
            rdata_d = (has_data && idx_ok) ? sel_word : 32'd0;
        end

        case (state_q)
            IDLE: begin
                if (curr_test_err) begin
                    shadow_d  = '0;
                    rd_mask_d = '0;
                end else if (ehr_full) begin
                    shadow_d  = ehr_data;
                    rd_mask_d = '0;
                    state_d   = LOADED;
                end
            end
            LOADED: begin
                if (curr_test_err) begin
                    shadow_d  = '0;
                    rd_mask_d = '0;
                    rdata_d   = rdata_q;
                    state_d   = IDLE;
                end else if (rd_hit) begin
                    // A CPU read always beats a same-cycle seed request
                    if (idx_ok) begin
                        rd_mask_d = rd_mask_q | hit_onehot;
`ifdef EHR_RD_ZEROIZE_EN
                        for (int i = 0; i < EHR_WORDS; i++) begin
                            if (hit_onehot[i]) begin
                                shadow_d[i*32 +: 32] = 32'd0;
                            end
                        end
`endif
                    end
                    if (&rd_mask_d) begin
                        state_d = DONE;
                    end
                end else if (prng_seed_req && (rd_mask_q == '0)) begin
                    state_d = SEED;
                end
            end
            SEED: begin
                if (curr_test_err) begin
                    shadow_d  = '0;
                    rd_mask_d = '0;
                    rdata_d   = rdata_q;
                    state_d   = IDLE;
                end else if (prng_seed_ack) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef EHR_RD_ZEROIZE_EN
        if ((state_d == DONE) && (state_q != DONE)) begin
            shadow_d = '0;
        end
`endif
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge rng_clk) begin
        if (rst_trng_logic) begin
            state_q   <= IDLE;
            shadow_q  <= '0;
            rd_mask_q <= '0;
            rdata_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            rd_mask_q <= rd_mask_d;
            rdata_q   <= rdata_d;
        end
    end

    assign ehr_rdata       = rdata_q;
    assign ehr_valid       = has_data;
    assign prng_seed_valid = (state_q == SEED);
    assign prng_seed_data  = (state_q == SEED) ? shadow_q : '0;
    assign ehr_rd_done     = (state_q == DONE);

endmodule

// File: tb/tb_ehr_reader.sv
// tb/tb_ehr_reader.sv - table-driven and directed checks for ehr_reader
module tb_ehr_reader;

    localparam int W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [32*W-1:0]   ehr_data;
    logic              ehr_full, curr_test_err, cpu_ehr_rd;
    logic [11:0]       paddr;
    logic              seed_req, seed_ack;
    logic [31:0]       ehr_rdata;
    logic              ehr_valid, seed_valid, rd_done;
    logic [32*W-1:0]   seed_data;

    int checks   = 0;
    int failures = 0;

    localparam logic [127:0] DATA = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
`ifdef EHR_RD_ZEROIZE_EN
    localparam logic [31:0] REPEAT_W0 = 32'h00000000;
`else
    localparam logic [31:0] REPEAT_W0 = 32'h11111111;
`endif

    ehr_reader #(.EHR_WORDS(W), .EHR_BASE_ADDR(12'h114)) dut (
        .rng_clk         (clk),
        .rst_trng_logic  (rst),
        .ehr_data        (ehr_data),
        .ehr_full        (ehr_full),
        .curr_test_err   (curr_test_err),
        .cpu_ehr_rd      (cpu_ehr_rd),
        .cpu_rng_paddr   (paddr),
        .prng_seed_req   (seed_req),
        .prng_seed_ack   (seed_ack),
        .ehr_rdata       (ehr_rdata),
        .ehr_valid       (ehr_valid),
        .prng_seed_valid (seed_valid),
        .prng_seed_data  (seed_data),
        .ehr_rd_done     (rd_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          full;
        bit          err;
        bit          rd;
        logic [11:0] addr;
        bit          req;
        bit          ack;
        bit          e_valid;
        bit          e_sv;
        bit          e_done;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Apply inputs for one cycle; outputs are sampled 1ns after the edge
    task automatic step(input bit f, input bit e, input bit r, input logic [11:0] a,
                        input bit q, input bit k);
        ehr_full      = f;
        curr_test_err = e;
        cpu_ehr_rd    = r;
        paddr         = a;
        seed_req      = q;
        seed_ack      = k;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_flags(input string nm, input bit v, input bit sv, input bit d);
        check({nm, "_valid"}, 128'(ehr_valid), 128'(v));
        check({nm, "_seedv"}, 128'(seed_valid), 128'(sv));
        check({nm, "_done"}, 128'(rd_done), 128'(d));
    endtask

    initial begin
        ehr_data = DATA;
        rst = 1'b1;
        step(0, 0, 0, 12'h000, 0, 0);
        step(0, 0, 0, 12'h000, 0, 0);
        chk_flags("reset", 0, 0, 0);
        check("reset_rdata", 128'(ehr_rdata), 128'h0);
        check("reset_seed_data", seed_data, 128'h0);
        rst = 1'b0;

        // Fill and full CPU drain, with repeat, out-of-window and out-of-range reads
        //                 name          full err rd addr     req ack  v sv dn rdata
        vecs.push_back('{"fill",          1, 0, 0, 12'h000, 0, 0, 1, 0, 0, 32'h00000000});
        vecs.push_back('{"rd118",         0, 0, 1, 12'h118, 0, 0, 1, 0, 0, 32'h22222222});
        vecs.push_back('{"rd114",         0, 0, 1, 12'h114, 0, 0, 1, 0, 0, 32'h11111111});
        vecs.push_back('{"rd114_rep",     0, 0, 1, 12'h114, 0, 0, 1, 0, 0, REPEAT_W0});
        vecs.push_back('{"rd_outwin",     0, 0, 1, 12'h200, 0, 0, 1, 0, 0, REPEAT_W0});
        vecs.push_back('{"rd124_oor",     0, 0, 1, 12'h124, 0, 0, 1, 0, 0, 32'h00000000});
        vecs.push_back('{"hold",          0, 0, 0, 12'h118, 0, 0, 1, 0, 0, 32'h00000000});
        vecs.push_back('{"rd120",         0, 0, 1, 12'h120, 0, 0, 1, 0, 0, 32'h44444444});
        vecs.push_back('{"rd11c_last",    0, 0, 1, 12'h11C, 0, 0, 0, 0, 1, 32'h33333333});
        vecs.push_back('{"done_full_ign", 1, 0, 0, 12'h000, 0, 0, 0, 0, 0, 32'h33333333});
        vecs.push_back('{"idle_after",    0, 0, 0, 12'h000, 0, 0, 0, 0, 0, 32'h33333333});
        vecs.push_back('{"rd_idle",       0, 0, 1, 12'h114, 0, 0, 0, 0, 0, 32'h00000000});

        foreach (vecs[i]) begin
            step(vecs[i].full, vecs[i].err, vecs[i].rd, vecs[i].addr, vecs[i].req, vecs[i].ack);
            chk_flags(vecs[i].name, vecs[i].e_valid, vecs[i].e_sv, vecs[i].e_done);
            check({vecs[i].name, "_rdata"}, 128'(ehr_rdata), 128'(vecs[i].e_rdata));
        end

        // Seed path with ack held low for 5 cycles
        step(1, 0, 0, 12'h000, 0, 0);
        check("seed_pre_data", seed_data, 128'h0);
        step(0, 0, 0, 12'h000, 1, 0);
        chk_flags("seed_enter", 1, 1, 0);
        check("seed_enter_data", seed_data, DATA);
        for (int c = 0; c < 5; c++) begin
            step(0, 0, 0, 12'h000, 1, 0);
            check($sformatf("seed_hold%0d_v", c), 128'(seed_valid), 128'h1);
            check($sformatf("seed_hold%0d_data", c), seed_data, DATA);
        end
        step(0, 0, 1, 12'h118, 1, 0);
        check("seed_cpu_rd", 128'(ehr_rdata), 128'h22222222);
        step(0, 0, 0, 12'h000, 1, 1);
        chk_flags("seed_ack", 0, 0, 1);
        check("seed_ack_data", seed_data, 128'h0);
        step(0, 0, 0, 12'h000, 0, 0);
        chk_flags("seed_idle", 0, 0, 0);

        // CPU read wins over a same-cycle seed request; later requests ignored
        step(1, 0, 0, 12'h000, 0, 0);
        step(0, 0, 1, 12'h114, 1, 0);
        chk_flags("conf_rd", 1, 0, 0);
        check("conf_rdata", 128'(ehr_rdata), 128'h11111111);
        for (int c = 0; c < 3; c++) begin
            step(0, 0, 0, 12'h000, 1, 0);
            check($sformatf("conf_req_ign%0d", c), 128'(seed_valid), 128'h0);
        end
        step(0, 0, 1, 12'h118, 1, 0);
        step(0, 0, 1, 12'h11C, 1, 0);
        check("conf_no_early_done", 128'(rd_done), 128'h0);
        step(0, 0, 1, 12'h120, 1, 0);
        chk_flags("conf_drained", 0, 0, 1);
        step(0, 0, 0, 12'h000, 0, 0);

        // Test error in SEED with same-cycle ack aborts without done
        step(1, 0, 0, 12'h000, 0, 0);
        step(0, 0, 0, 12'h000, 1, 0);
        check("err_in_seed", 128'(seed_valid), 128'h1);
        step(0, 1, 0, 12'h000, 1, 1);
        chk_flags("err_abort", 0, 0, 0);
        check("err_seed_data", seed_data, 128'h0);
        step(0, 0, 1, 12'h114, 0, 0);
        chk_flags("err_after", 0, 0, 0);
        check("err_rd_zero", 128'(ehr_rdata), 128'h0);

        // Reset on the cycle of the final draining read suppresses done
        step(1, 0, 0, 12'h000, 0, 0);
        step(0, 0, 1, 12'h114, 0, 0);
        step(0, 0, 1, 12'h118, 0, 0);
        step(0, 0, 1, 12'h11C, 0, 0);
        check("rst_mid_rdata_pre", 128'(ehr_rdata), 128'h33333333);
        rst = 1'b1;
        step(0, 0, 1, 12'h120, 0, 0);
        chk_flags("rst_mid", 0, 0, 0);
        check("rst_mid_rdata", 128'(ehr_rdata), 128'h0);
        rst = 1'b0;
        step(0, 0, 0, 12'h000, 0, 0);
        chk_flags("rst_mid_after", 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
